// File: rtl/mux_4_pkg.sv
// Shared constants for the registered 4:1 lane selector.
// Lane count, select width and the value driven when disabled or in reset.
package mux_4_pkg;

  localparam int   SEL_W     = 2;
  localparam int   NUM_LANES = 4;

  // Every bit of Y takes this value when disabled or in reset.
  localparam logic OFF_BIT   = 1'b0;

endpackage : mux_4_pkg

// File: rtl/mux4_sel.sv
// Combinational 4:1 lane select with active-low enable gating.
// The output is forced to OFF_BIT on every bit while en_n_i is high.
module mux4_sel
  import mux_4_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic [SEL_W-1:0]            sel_i,
  input  logic [NUM_LANES*LANE_W-1:0] lanes_i,
  input  logic                        en_n_i,
  output logic [LANE_W-1:0]           y_o
);

  logic [LANE_W-1:0] lane_arr [NUM_LANES];

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_arr[gi] = lanes_i[gi*LANE_W +: LANE_W];
  end

  always_comb begin
    y_o = {LANE_W{OFF_BIT}};
    if (!en_n_i) begin
      y_o = lane_arr[sel_i];
    end
  end

endmodule : mux4_sel

// File: rtl/mux_4.sv
// Registered 4:1 selector: one-cycle latency from S/I/E to Y.
// Reset is synchronous and overrides the enable and the select.
module mux_4
  import mux_4_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEL_W-1:0]            S,
  input  logic [NUM_LANES*LANE_W-1:0] I,
  input  logic                        E,
  output logic [LANE_W-1:0]           Y
);

  logic [LANE_W-1:0] y_d;
  logic [LANE_W-1:0] y_q;

  mux4_sel #(
    .LANE_W (LANE_W)
  ) u_sel (
    .sel_i   (S),
    .lanes_i (I),
    .en_n_i  (E),
    .y_o     (y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= {LANE_W{OFF_BIT}};
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule : mux_4

// File: tb/tb_mux_4.sv
// Directed bench for mux_4: a 1-bit-lane and an 8-bit-lane instance
// sharing clock, reset, enable and select.
module tb_mux_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  S;
  logic        E;
  logic [3:0]  I1;
  logic [31:0] I8;
  logic        y1;
  logic [7:0]  y8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_4 #(.LANE_W(1)) u_dut1 (
    .clk (clk), .rst (rst), .S (S), .I (I1), .E (E), .Y (y1)
  );

  mux_4 #(.LANE_W(8)) u_dut8 (
    .clk (clk), .rst (rst), .S (S), .I (I8), .E (E), .Y (y8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wide_exp [4];

  initial begin
    wide_exp[0] = 8'hAA;
    wide_exp[1] = 8'hBB;
    wide_exp[2] = 8'hCC;
    wide_exp[3] = 8'hDD;

    rst = 1'b1; E = 1'b0; S = 2'd0; I1 = 4'b1001; I8 = 32'hDDCCBBAA;
    step();
    check("reset_c1", 32'(y1), 32'h0);
    check("reset_c1_wide", 32'(y8), 32'h0);
    step();
    check("reset_c2", 32'(y1), 32'h0);
    rst = 1'b0;
    step();
    check("post_reset_s0", 32'(y1), 32'h1);
    check("post_reset_wide_s0", 32'(y8), 32'hAA);

    // Disabled: every select yields zero.
    E = 1'b1;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      step();
      check($sformatf("disable_s%0d", s), 32'(y1), 32'h0);
    end
    check("disable_wide", 32'(y8), 32'h0);

    // Enabled sweep over I=1001 with S = 1,2,3,0.
    E = 1'b0;
    S = 2'd1; step(); check("sweep_s1", 32'(y1), 32'h0);
    S = 2'd2; step(); check("sweep_s2", 32'(y1), 32'h0);
    S = 2'd3; step(); check("sweep_s3", 32'(y1), 32'h1);
    S = 2'd0; step(); check("sweep_s0_wrap", 32'(y1), 32'h1);

    // Walking one, matched and mismatched select.
    for (int k = 0; k < 4; k++) begin
      I1 = 4'(1 << k);
      S  = 2'(k);
      step();
      check($sformatf("walk_match_%0d", k), 32'(y1), 32'h1);
      S = 2'((k + 1) % 4);
      #1;
      check($sformatf("walk_hold_%0d", k), 32'(y1), 32'h1);
      step();
      check($sformatf("walk_miss_%0d", k), 32'(y1), 32'h0);
    end

    // Priority: rst > E > select.
    I1 = 4'hF; S = 2'd1;
    rst = 1'b1; E = 1'b1; step(); check("prio_rst_dis", 32'(y1), 32'h0);
    rst = 1'b1; E = 1'b0; step(); check("prio_rst_en", 32'(y1), 32'h0);
    check("prio_rst_en_wide", 32'(y8), 32'h0);
    rst = 1'b0; E = 1'b1; step(); check("prio_dis_only", 32'(y1), 32'h0);
    E = 1'b0;             step(); check("prio_enabled", 32'(y1), 32'h1);

    // Wide lanes.
    I8 = 32'hDDCCBBAA;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      step();
      check($sformatf("wide_s%0d", s), 32'(y8), 32'(wide_exp[s]));
    end
    S = 2'd2; I8 = 32'h11223344; step();
    check("wide_new_i_s2", 32'(y8), 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_4
